trace_capture_ctrl: RTL and testbench
=====================================

// Module: trace_capture_ctrl
// PURPOSE
//  Sequences one trace capture: arm, wait for trace sync, wait for a trigger, write a bounded run of words, stop.
//  Triggers come from enabled pattern-match rules or the soft trigger.
//  Sits between the trace register block, pattern matcher and capture FIFO.
//  Gates FIFO writes and reports status back to the register block.
// PARAMETERS
//  pMATCH_RULES   8   number of pattern-match rules (<=15)
//  pCOUNT_WIDTH   16  width of capture length / word counter
//  pTIMEOUT_WIDTH 24  width of arm timeout counter
// PORTS
//  usb_clk                in   1               block clock; all inputs already synchronous to it
//  reset_i                in   1               asynchronous, active-high reset
//  I_arm                  in   1               1-cycle pulse: start a capture sequence
//  I_abort                in   1               1-cycle pulse (reset_sync): return to IDLE
//  I_synchronized         in   1               trace decoder has sync
//  I_match                in   pMATCH_RULES    per-rule match pulse from matcher
//  I_pattern_trig_enable  in   pMATCH_RULES    rules allowed to trigger
//  I_soft_trig_enable     in   1               soft trigger allowed
//  I_soft_trig            in   1               soft trigger pulse
//  I_capture_len          in   pCOUNT_WIDTH    words to capture; 0 = unlimited
//  I_timeout              in   pTIMEOUT_WIDTH  max cycles in WAIT_SYNC+ARMED; 0 = none
//  I_data_valid           in   1               datapath word available this cycle
//  I_fifo_full            in   1               capture FIFO full
//  O_fifo_wr              out  1               write strobe to FIFO
//  O_capture_en           out  1               high in CAPTURE
//  O_trigger_out          out  1               1-cycle pulse on trigger acceptance
//  O_trig_src             out  4               winning rule index; 4'hF = soft trigger
//  O_words                out  pCOUNT_WIDTH    words written this capture; saturating
//  O_state                out  3               current FSM state
//  O_done                 out  1               1-cycle pulse on entry to DONE
//  O_overflow             out  1               sticky: valid word dropped because FIFO full
//  O_timed_out            out  1               sticky: timeout expired before trigger
//  O_sync_lost            out  1               sticky: sync dropped during CAPTURE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except O_trig_src=0; all counters 0.
//  States: IDLE=0, WAIT_SYNC=1, ARMED=2, CAPTURE=3, DONE=4.
//  IDLE/DONE + I_arm -> WAIT_SYNC.
//   - Clears O_words, the timeout counter and all stickies.
//   - I_arm is ignored in WAIT_SYNC, ARMED and CAPTURE.
//  WAIT_SYNC + I_synchronized -> ARMED (1 cycle).
//  ARMED + trigger -> CAPTURE.
//   - trigger = |(I_match & I_pattern_trig_enable) | (I_soft_trig & I_soft_trig_enable).
//   - Rules win over soft; the lowest-index enabled matching rule wins.
//   - O_trig_src is registered and held until the next arm.
//   - Trigger in cycle N gives O_trigger_out=1 and state=CAPTURE in N+1.
//   - The first O_fifo_wr is possible in N+1.
//   - Triggers outside ARMED are ignored.
//  Timeout:
//   - The counter increments in WAIT_SYNC and ARMED.
//   - When count == I_timeout (nonzero) and no trigger that cycle: -> DONE with O_timed_out=1.
//   - A trigger in the same cycle beats the timeout.
//  CAPTURE:
//   - O_fifo_wr = I_data_valid & ~I_fifo_full. This is combinational from registered state.
//   - I_data_valid & I_fifo_full sets O_overflow; the word is dropped and not counted; capture continues.
//   - O_words increments per write and saturates at all-ones.
//   - After the write that makes O_words == I_capture_len (nonzero): -> DONE; no further writes.
//   - I_synchronized=0 -> DONE with O_sync_lost=1; no write that cycle.
//  DONE: O_done pulses 1 cycle on entry; the state holds until I_arm or I_abort.
//  I_abort from any state -> IDLE next cycle.
//   - Clears O_capture_en; O_fifo_wr=0 in the abort cycle.
//   - Stickies and O_words are kept for readback.
//   - Abort beats arm in the same cycle.
//  I_capture_len and I_timeout are sampled continuously; software changes them only in IDLE/DONE.
//  Reset mid-capture: immediate return to reset values; no partial pulse.
// STRUCTURE
//  FSM state encodings and the 4'hF soft-trigger code go in defines_trace.v beside the register addresses.
//  One sub-module: trace_trig_select, a combinational priority encoder over masked matches.
//   - Outputs: hit, index.
//  Counters and FSM stay in this module.
// TESTING
//  1. arm, sync=1, I_match[5] with enable 8'h20, len=4, valid every cycle
//     -> trigger_out at N+1, trig_src=5, exactly 4 writes, words=4, done pulse, state DONE.
//  2. Matches [2] and [6] both enabled, same cycle as soft_trig
//     -> trig_src=2; soft alone with soft_trig_enable=1 -> trig_src=4'hF.
//  3. arm, sync=0, timeout=100
//     -> DONE after 100 cycles, timed_out=1, no writes.
//     Trigger on the expiry cycle -> CAPTURE, timed_out=0.
//  4. CAPTURE with len=10 and fifo_full held 3 valid cycles
//     -> overflow=1, those 3 words not written, capture still ends at words=10.
//  5. Abort in CAPTURE with arm in the same cycle
//     -> IDLE next cycle, fifo_wr=0 from the abort cycle, words retained.
//     Arm while ARMED -> ignored.
//  6. Drop sync mid-capture with len=0 -> DONE, sync_lost=1.
//     Assert reset_i asynchronously mid-capture -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/trace_capture_ctrl_pkg.sv
// Shared types and constants for the trace capture controller.
package trace_capture_ctrl_pkg;

   // Capture sequencer states; the numeric values are visible on O_state.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SYNC = 3'd1,
      ST_ARMED     = 3'd2,
      ST_CAPTURE   = 3'd3,
      ST_DONE      = 3'd4
   } trace_state_e;

   // Trigger source code reported when the soft trigger wins.
   localparam logic [3:0] SOFT_TRIG_SRC = 4'hF;

endpackage

// File: rtl/trace_trig_select.sv
// Priority encoder over the masked pattern-match vector: lowest set index wins.
module trace_trig_select #(
   parameter int pMATCH_RULES = 8
) (
   input  logic [pMATCH_RULES-1:0] match_i,
   output logic                    hit_o,
   output logic [3:0]              index_o
);

   // Scan from the top down so the lowest-index match is the last one written.
   always_comb begin
      hit_o   = 1'b0;
      index_o = 4'd0;
      for (int i = pMATCH_RULES - 1; i >= 0; i--) begin
         hit_o   = hit_o | match_i[i];
         index_o = match_i[i] ? 4'(i) : index_o;
      end
   end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm, wait for sync, wait for trigger, capture a
// bounded run of words into the FIFO, then stop and report status.
module trace_capture_ctrl
   import trace_capture_ctrl_pkg::*;
#(
   parameter int pMATCH_RULES   = 8,
   parameter int pCOUNT_WIDTH   = 16,
   parameter int pTIMEOUT_WIDTH = 24
) (
   input  logic                      usb_clk,
   input  logic                      reset_i,
   input  logic                      I_arm,
   input  logic                      I_abort,
   input  logic                      I_synchronized,
   input  logic [pMATCH_RULES-1:0]   I_match,
   input  logic [pMATCH_RULES-1:0]   I_pattern_trig_enable,
   input  logic                      I_soft_trig_enable,
   input  logic                      I_soft_trig,
   input  logic [pCOUNT_WIDTH-1:0]   I_capture_len,
   input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
   input  logic                      I_data_valid,
   input  logic                      I_fifo_full,
   output logic                      O_fifo_wr,
   output logic                      O_capture_en,
   output logic                      O_trigger_out,
   output logic [3:0]                O_trig_src,
   output logic [pCOUNT_WIDTH-1:0]   O_words,
   output logic [2:0]                O_state,
   output logic                      O_done,
   output logic                      O_overflow,
   output logic                      O_timed_out,
   output logic                      O_sync_lost
);

   trace_state_e              state_q;
   logic                      capture_en_q;
   logic                      trigger_q;
   logic [3:0]                trig_src_q;
   logic [pCOUNT_WIDTH-1:0]   words_q;
   logic [pTIMEOUT_WIDTH-1:0] tmo_cnt_q;
   logic                      done_q;
   logic                      overflow_q;
   logic                      timed_out_q;
   logic                      sync_lost_q;

   logic                      rule_hit_s;
   logic [3:0]                rule_idx_s;
   logic                      trig_fire_s;
   logic [3:0]                trig_src_d;
   logic [pTIMEOUT_WIDTH-1:0] tmo_cnt_d;
   logic                      tmo_expire_s;
   logic [pCOUNT_WIDTH-1:0]   words_d;
   logic                      len_reached_s;
   logic                      wr_s;

   trace_trig_select #(
      .pMATCH_RULES (pMATCH_RULES)
   ) u_trig_select (
      .match_i (I_match & I_pattern_trig_enable),
      .hit_o   (rule_hit_s),
      .index_o (rule_idx_s)
   );

   // Trigger qualification, counter increments and the FIFO write gate.
   always_comb begin
      trig_fire_s   = rule_hit_s | (I_soft_trig & I_soft_trig_enable);
      trig_src_d    = rule_hit_s ? rule_idx_s : SOFT_TRIG_SRC;
      // Post-increment value: the number of cycles spent waiting, this one included.
      tmo_cnt_d     = tmo_cnt_q + pTIMEOUT_WIDTH'(1);
      tmo_expire_s  = (I_timeout != '0) && (tmo_cnt_d == I_timeout);
      words_d       = (&words_q) ? words_q : (words_q + pCOUNT_WIDTH'(1));
      len_reached_s = (I_capture_len != '0) && (words_d == I_capture_len);
      wr_s          = (state_q == ST_CAPTURE) & I_data_valid & ~I_fifo_full
                      & I_synchronized & ~I_abort;
   end

   // Capture sequencer with its registered status outputs and counters.
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         capture_en_q <= 1'b0;
         trigger_q    <= 1'b0;
         trig_src_q   <= 4'd0;
         words_q      <= '0;
         tmo_cnt_q    <= '0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
         timed_out_q  <= 1'b0;
         sync_lost_q  <= 1'b0;
      end else begin
         trigger_q <= 1'b0;
         done_q    <= 1'b0;
         if (I_abort) begin
            // Abort wins over everything; status stays for readback.
            state_q      <= ST_IDLE;
            capture_en_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (I_arm) begin
                     state_q     <= ST_WAIT_SYNC;
                     words_q     <= '0;
                     tmo_cnt_q   <= '0;
                     trig_src_q  <= 4'd0;
                     overflow_q  <= 1'b0;
                     timed_out_q <= 1'b0;
                     sync_lost_q <= 1'b0;
                  end
               end
               ST_WAIT_SYNC: begin
                  tmo_cnt_q <= tmo_cnt_d;
                  if (tmo_expire_s) begin
                     state_q     <= ST_DONE;
                     timed_out_q <= 1'b1;
                     done_q      <= 1'b1;
                  end else if (I_synchronized) begin
                     state_q <= ST_ARMED;
                  end
               end
               ST_ARMED: begin
                  tmo_cnt_q <= tmo_cnt_d;
                  if (trig_fire_s) begin
                     state_q      <= ST_CAPTURE;
                     capture_en_q <= 1'b1;
                     trigger_q    <= 1'b1;
                     trig_src_q   <= trig_src_d;
                  end else if (tmo_expire_s) begin
                     state_q     <= ST_DONE;
                     timed_out_q <= 1'b1;
                     done_q      <= 1'b1;
                  end
               end
               ST_CAPTURE: begin
                  if (!I_synchronized) begin
                     state_q      <= ST_DONE;
                     capture_en_q <= 1'b0;
                     sync_lost_q  <= 1'b1;
                     done_q       <= 1'b1;
                  end else begin
                     if (I_data_valid && I_fifo_full) begin
                        overflow_q <= 1'b1;
                     end
                     if (wr_s) begin
                        words_q <= words_d;
                        if (len_reached_s) begin
                           state_q      <= ST_DONE;
                           capture_en_q <= 1'b0;
                           done_q       <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  state_q      <= ST_IDLE;
                  capture_en_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign O_fifo_wr     = wr_s;
   assign O_capture_en  = capture_en_q;
   assign O_trigger_out = trigger_q;
   assign O_trig_src    = trig_src_q;
   assign O_words       = words_q;
   assign O_state       = state_q;
   assign O_done        = done_q;
   assign O_overflow    = overflow_q;
   assign O_timed_out   = timed_out_q;
   assign O_sync_lost   = sync_lost_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Self-checking bench for trace_capture_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural model of the sequence.
module tb_trace_capture_ctrl;

   localparam int R  = 8;
   localparam int CW = 16;
   localparam int TW = 24;

   localparam int M_IDLE = 0, M_WAIT = 1, M_ARMED = 2, M_CAPTURE = 3, M_DONE = 4;

   logic          usb_clk = 1'b0;
   logic          reset_i;
   logic          I_arm, I_abort, I_synchronized;
   logic [R-1:0]  I_match, I_pattern_trig_enable;
   logic          I_soft_trig_enable, I_soft_trig;
   logic [CW-1:0] I_capture_len;
   logic [TW-1:0] I_timeout;
   logic          I_data_valid, I_fifo_full;
   logic          O_fifo_wr, O_capture_en, O_trigger_out;
   logic [3:0]    O_trig_src;
   logic [CW-1:0] O_words;
   logic [2:0]    O_state;
   logic          O_done, O_overflow, O_timed_out, O_sync_lost;

   always #5 usb_clk = ~usb_clk;

   trace_capture_ctrl #(
      .pMATCH_RULES(R), .pCOUNT_WIDTH(CW), .pTIMEOUT_WIDTH(TW)
   ) dut (
      .usb_clk(usb_clk), .reset_i(reset_i), .I_arm(I_arm), .I_abort(I_abort),
      .I_synchronized(I_synchronized), .I_match(I_match),
      .I_pattern_trig_enable(I_pattern_trig_enable),
      .I_soft_trig_enable(I_soft_trig_enable), .I_soft_trig(I_soft_trig),
      .I_capture_len(I_capture_len), .I_timeout(I_timeout),
      .I_data_valid(I_data_valid), .I_fifo_full(I_fifo_full),
      .O_fifo_wr(O_fifo_wr), .O_capture_en(O_capture_en),
      .O_trigger_out(O_trigger_out), .O_trig_src(O_trig_src),
      .O_words(O_words), .O_state(O_state), .O_done(O_done),
      .O_overflow(O_overflow), .O_timed_out(O_timed_out),
      .O_sync_lost(O_sync_lost)
   );

   int checks    = 0;
   int failures  = 0;
   int wr_seen   = 0;
   int done_seen = 0;

   // Behavioural view of one capture sequence.
   int m_state, m_words, m_since_arm, m_src;
   bit m_trig, m_done, m_ovf, m_tmo, m_slost;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_words = 0; m_since_arm = 0; m_src = 0;
      m_trig = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_slost = 1'b0;
   endtask

   // -1: no trigger; 0..R-1: winning rule; 15: soft trigger.
   function automatic int winner();
      for (int i = 0; i < R; i++)
         if (I_match[i] && I_pattern_trig_enable[i]) return i;
      if (I_soft_trig && I_soft_trig_enable) return 15;
      return -1;
   endfunction

   function automatic bit model_wr();
      return (m_state == M_CAPTURE) && I_data_valid && !I_fifo_full
             && I_synchronized && !I_abort;
   endfunction

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      bit wr;
      int w;
      wr = model_wr();
      w  = winner();
      m_trig = 1'b0;
      m_done = 1'b0;
      if (I_abort) begin
         m_state = M_IDLE;
      end else if ((m_state == M_IDLE || m_state == M_DONE) && I_arm) begin
         m_state = M_WAIT; m_words = 0; m_since_arm = 0; m_src = 0;
         m_ovf = 1'b0; m_tmo = 1'b0; m_slost = 1'b0;
      end else if (m_state == M_WAIT || m_state == M_ARMED) begin
         m_since_arm++;
         if (m_state == M_ARMED && w >= 0) begin
            m_state = M_CAPTURE; m_trig = 1'b1; m_src = w;
         end else if (I_timeout != 0 && m_since_arm == int'(I_timeout)) begin
            m_state = M_DONE; m_tmo = 1'b1; m_done = 1'b1;
         end else if (m_state == M_WAIT && I_synchronized) begin
            m_state = M_ARMED;
         end
      end else if (m_state == M_CAPTURE) begin
         if (!I_synchronized) begin
            m_state = M_DONE; m_slost = 1'b1; m_done = 1'b1;
         end else begin
            if (I_data_valid && I_fifo_full) m_ovf = 1'b1;
            if (wr) begin
               m_words = (m_words < 65535) ? m_words + 1 : 65535;
               if (I_capture_len != 0 && m_words == int'(I_capture_len)) begin
                  m_state = M_DONE; m_done = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic check_regs();
      check_eq("state",      32'(O_state),       32'(m_state));
      check_eq("capture_en", 32'(O_capture_en),  32'(m_state == M_CAPTURE));
      check_eq("trigger",    32'(O_trigger_out), 32'(m_trig));
      check_eq("trig_src",   32'(O_trig_src),    32'(m_src));
      check_eq("words",      32'(O_words),       32'(m_words));
      check_eq("done",       32'(O_done),        32'(m_done));
      check_eq("overflow",   32'(O_overflow),    32'(m_ovf));
      check_eq("timed_out",  32'(O_timed_out),   32'(m_tmo));
      check_eq("sync_lost",  32'(O_sync_lost),   32'(m_slost));
   endtask

   // One clock: called at posedge+1 with inputs already applied.
   task automatic cycle();
      #4;
      check_eq("fifo_wr", 32'(O_fifo_wr), 32'(model_wr()));
      if (O_fifo_wr) wr_seen++;
      @(posedge usb_clk);
      model_step();
      #1;
      check_regs();
      if (O_done) done_seen++;
   endtask

   task automatic clear_pulses();
      I_arm = 1'b0; I_abort = 1'b0; I_match = '0; I_soft_trig = 1'b0;
   endtask

   // Run until the DUT reports DONE or the cycle budget is spent.
   task automatic run_to_done(input string tag, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (O_state == 3'd4) break;
         cycle();
      end
      check_eq(tag, 32'(O_state), 32'd4);
   endtask

   initial begin
      reset_i = 1'b1;
      clear_pulses();
      I_synchronized = 1'b0; I_pattern_trig_enable = '0; I_soft_trig_enable = 1'b0;
      I_capture_len = '0; I_timeout = '0; I_data_valid = 1'b0; I_fifo_full = 1'b0;
      model_reset();
      @(posedge usb_clk); #1;
      @(posedge usb_clk); #1;
      check_regs();
      check_eq("reset_fifo_wr", 32'(O_fifo_wr), 32'd0);
      reset_i = 1'b0;

      // 1: rule 5 trigger, length 4
      I_capture_len = 16'd4; I_pattern_trig_enable = 8'h20;
      I_synchronized = 1'b1; I_data_valid = 1'b1;
      I_arm = 1'b1; cycle(); I_arm = 1'b0;
      cycle();
      check_eq("t1_armed", 32'(O_state), 32'd2);
      I_match = 8'h20; cycle(); I_match = '0;
      check_eq("t1_trigger_out", 32'(O_trigger_out), 32'd1);
      check_eq("t1_trig_src", 32'(O_trig_src), 32'd5);
      wr_seen = 0; done_seen = 0;
      run_to_done("t1_done_state", 20);
      cycle(); cycle();
      check_eq("t1_writes", 32'(wr_seen), 32'd4);
      check_eq("t1_words", 32'(O_words), 32'd4);
      check_eq("t1_done_pulses", 32'(done_seen), 32'd1);

      // 2: rule priority over rules and soft, then soft alone
      I_capture_len = 16'd1; I_pattern_trig_enable = 8'h44; I_soft_trig_enable = 1'b1;
      I_arm = 1'b1; cycle(); I_arm = 1'b0; cycle();
      I_match = 8'h44; I_soft_trig = 1'b1; cycle(); clear_pulses();
      check_eq("t2_rule_src", 32'(O_trig_src), 32'd2);
      run_to_done("t2a_done", 10);
      I_arm = 1'b1; cycle(); I_arm = 1'b0; cycle();
      I_soft_trig = 1'b1; cycle(); clear_pulses();
      check_eq("t2_soft_src", 32'(O_trig_src), 32'hF);
      run_to_done("t2b_done", 10);

      // 3: timeout expiry without sync, then trigger on the expiry cycle
      I_synchronized = 1'b0; I_timeout = 24'd100; I_capture_len = 16'd10;
      I_pattern_trig_enable = 8'h20; wr_seen = 0;
      I_arm = 1'b1; cycle(); I_arm = 1'b0;
      for (int k = 0; k < 99; k++) cycle();
      check_eq("t3_still_waiting", 32'(O_state), 32'd1);
      cycle();
      check_eq("t3_timeout_state", 32'(O_state), 32'd4);
      check_eq("t3_timed_out", 32'(O_timed_out), 32'd1);
      check_eq("t3_no_writes", 32'(wr_seen), 32'd0);
      I_synchronized = 1'b1;
      I_arm = 1'b1; cycle(); I_arm = 1'b0;
      for (int k = 0; k < 99; k++) cycle();
      check_eq("t3_armed_before_expiry", 32'(O_state), 32'd2);
      I_match = 8'h20; cycle(); I_match = '0;
      check_eq("t3_trig_beats_timeout", 32'(O_state), 32'd3);
      check_eq("t3_not_timed_out", 32'(O_timed_out), 32'd0);

      // 4: FIFO full for 3 valid cycles during a 10-word capture
      wr_seen = 0; I_fifo_full = 1'b1;
      cycle(); cycle(); cycle();
      I_fifo_full = 1'b0;
      run_to_done("t4_done", 30);
      check_eq("t4_overflow", 32'(O_overflow), 32'd1);
      check_eq("t4_words", 32'(O_words), 32'd10);
      check_eq("t4_writes", 32'(wr_seen), 32'd10);

      // 5: abort with arm in CAPTURE; arm while ARMED is ignored
      I_capture_len = 16'd0; I_timeout = 24'd0;
      I_arm = 1'b1; cycle(); I_arm = 1'b0; cycle();
      I_match = 8'h20; cycle(); I_match = '0;
      cycle(); cycle(); cycle();
      I_abort = 1'b1; I_arm = 1'b1;
      #4 check_eq("t5_no_wr_in_abort", 32'(O_fifo_wr), 32'd0);
      #6 model_step(); #1 check_regs();
      clear_pulses();
      check_eq("t5_idle", 32'(O_state), 32'd0);
      check_eq("t5_words_kept", 32'(O_words), 32'd3);
      I_arm = 1'b1; cycle(); I_arm = 1'b0; cycle();
      I_arm = 1'b1; cycle(); I_arm = 1'b0;
      check_eq("t5_arm_ignored", 32'(O_state), 32'd2);

      // 6: sync loss mid-capture, then asynchronous reset mid-capture
      I_match = 8'h20; cycle(); I_match = '0;
      cycle(); cycle();
      I_synchronized = 1'b0; cycle();
      check_eq("t6_sync_lost_state", 32'(O_state), 32'd4);
      check_eq("t6_sync_lost", 32'(O_sync_lost), 32'd1);
      I_synchronized = 1'b1;
      I_arm = 1'b1; cycle(); I_arm = 1'b0; cycle();
      I_match = 8'h20; cycle(); I_match = '0;
      cycle();
      #2 reset_i = 1'b1;
      #1;
      model_reset();
      check_regs();
      check_eq("t6_reset_fifo_wr", 32'(O_fifo_wr), 32'd0);
      @(posedge usb_clk); #1;
      reset_i = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if (m_state == M_IDLE || m_state == M_DONE) begin
            I_capture_len = CW'($urandom_range(0, 11));
            I_timeout     = TW'($urandom_range(0, 30));
         end
         I_arm   = ($urandom_range(0, 7) == 0);
         I_abort = ($urandom_range(0, 63) == 0);
         I_synchronized = ($urandom_range(0, 15) != 0);
         I_match = R'($urandom & $urandom & $urandom);
         I_pattern_trig_enable = R'($urandom);
         I_soft_trig = ($urandom_range(0, 5) == 0);
         I_soft_trig_enable = $urandom_range(0, 1) == 1;
         I_data_valid = ($urandom_range(0, 3) != 0);
         I_fifo_full = ($urandom_range(0, 4) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
